// File: rtl/npc_pipe_pkg.sv
// npc_defs: shared control-flow op codes and next-PC FSM state encodings.
package npc_defs;
    typedef enum logic [1:0] {
        NPC_PC4  = 2'b00,
        NPC_JALR = 2'b01,
        NPC_B    = 2'b10,
        NPC_JAL  = 2'b11
    } npc_op_e;
    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } npc_state_e;
endpackage

// File: rtl/npc_btb.sv
// npc_btb: direct-mapped branch target buffer with one lookup and one update port.
module npc_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:2] lk_pc_i,
    output logic            hit_o,
    output logic [XLEN-1:0] tgt_o,
    input  logic            upd_i,
    input  logic            inv_i,
    input  logic [XLEN-1:2] upd_pc_i,
    input  logic [XLEN-1:0] upd_tgt_i
);
    localparam int IW = $clog2(ENTRIES);
    logic [ENTRIES-1:0]   valid_q;
    logic [XLEN-1:IW+2]   tag_q [ENTRIES];
    logic [XLEN-1:0]      tgt_q [ENTRIES];
    logic [IW-1:0]        lk_idx, up_idx;
    logic                 up_match;
    // Lookup reads registered contents, so a same-cycle update is seen only next cycle.
    always_comb begin
        lk_idx   = lk_pc_i[IW+1:2];
        up_idx   = upd_pc_i[IW+1:2];
        hit_o    = valid_q[lk_idx] && tag_q[lk_idx] == lk_pc_i[XLEN-1:IW+2];
        tgt_o    = tgt_q[lk_idx];
        up_match = valid_q[up_idx] && tag_q[up_idx] == upd_pc_i[XLEN-1:IW+2];
    end
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else if (upd_i) valid_q[up_idx] <= 1'b1;
        else if (inv_i && up_match) valid_q[up_idx] <= 1'b0;
    end
    always_ff @(posedge clk) begin
        if (!rst && upd_i) begin
            tag_q[up_idx] <= upd_pc_i[XLEN-1:IW+2];
            tgt_q[up_idx] <= upd_tgt_i;
        end
    end
endmodule

// File: rtl/npc_pipe.sv
// npc_pipe: pipelined next-PC unit with EX-stage redirect; define NPC_BTB_EN to add
// a BTB predictor (otherwise pred_npc is always pc+4).
module npc_pipe
    import npc_defs::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [XLEN-1:0] TRAP_PC     = XLEN'('h100),
    parameter int              BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_ready,
    input  logic            stall,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] pred_npc,
    input  logic            ex_valid,
    input  logic [1:0]      ex_op,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_offset,
    input  logic [XLEN-1:0] ex_jalr_tgt,
    input  logic [XLEN-1:0] ex_pred_npc,
    output logic            flush,
    output logic            misalign
);
    npc_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, act;
    logic            flush_q, misalign_q, mis, misp, adv, xfer;
    always_comb begin
        xfer = ex_op == NPC_JAL || (ex_op == NPC_B && ex_taken);
        act  = ex_op == NPC_JALR ? (ex_jalr_tgt & {{(XLEN-1){1'b1}}, 1'b0}) :
               xfer ? ex_pc + ex_offset : ex_pc + XLEN'(4);
        mis  = ex_valid && act[1];
        misp = ex_valid && act != ex_pred_npc;
        adv  = pc_valid && if_ready && !stall;
        pc_d = mis ? TRAP_PC : misp ? act : adv ? pred_npc : pc_q;
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_BOOT;
        else state_q <= state_d;
    end
    // Any redirect reopens fetch; BOOT always lasts exactly one cycle.
    always_comb begin
        state_d = (mis || misp || state_q == S_BOOT) ? S_RUN :
                  (stall || !if_ready) ? S_HOLD : S_RUN;
    end
    always_comb begin
        pc_valid = state_q != S_BOOT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            flush_q    <= mis || misp;
            misalign_q <= mis;
        end
    end
    assign pc       = pc_q;
    assign pc4      = pc_q + XLEN'(4);
    assign flush    = flush_q;
    assign misalign = misalign_q;
`ifdef NPC_BTB_EN
    logic            btb_hit, btb_upd, btb_inv;
    logic [XLEN-1:0] btb_tgt;
    assign btb_upd  = ex_valid && !mis && (xfer || ex_op == NPC_JALR);
    assign btb_inv  = ex_valid && !mis && ex_op == NPC_B && !ex_taken;
    assign pred_npc = btb_hit ? btb_tgt : pc4;
    npc_btb #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .lk_pc_i   (pc_q[XLEN-1:2]),
        .hit_o     (btb_hit),
        .tgt_o     (btb_tgt),
        .upd_i     (btb_upd),
        .inv_i     (btb_inv),
        .upd_pc_i  (ex_pc[XLEN-1:2]),
        .upd_tgt_i (act)
    );
`else
    assign pred_npc = pc4;
`endif
endmodule

// File: tb/tb_npc_pipe.sv
// tb_npc_pipe: directed vector table, randomized run against a behavioural model,
// and (with NPC_BTB_EN) a BTB reuse/invalidate sequence.
module tb_npc_pipe;
    import npc_defs::*;
    logic        clk = 1'b0, rst = 1'b1, if_ready = 1'b0, stall = 1'b0;
    logic        ex_valid = 1'b0, ex_taken = 1'b0;
    logic [1:0]  ex_op = 2'b00;
    logic [31:0] ex_pc = '0, ex_offset = '0, ex_jalr_tgt = '0, ex_pred_npc = '0;
    logic        pc_valid, flush, misalign;
    logic [31:0] pc, pc4, pred_npc;
    int          checks = 0, errors = 0;

    npc_pipe dut (
        .clk(clk), .rst(rst), .if_ready(if_ready), .stall(stall),
        .pc_valid(pc_valid), .pc(pc), .pc4(pc4), .pred_npc(pred_npc),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_taken(ex_taken), .ex_pc(ex_pc),
        .ex_offset(ex_offset), .ex_jalr_tgt(ex_jalr_tgt), .ex_pred_npc(ex_pred_npc),
        .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && !pc_valid)
            assert (!ex_valid) else $error("FAIL boot_redirect ex_valid=%0b while booting", ex_valid);

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rdy, input logic st, input logic ev,
                         input logic [1:0] op, input logic tk, input logic [31:0] epc,
                         input logic [31:0] off, input logic [31:0] jt, input logic [31:0] pr);
        rst = r; if_ready = rdy; stall = st; ex_valid = ev; ex_op = op; ex_taken = tk;
        ex_pc = epc; ex_offset = off; ex_jalr_tgt = jt; ex_pred_npc = pr;
    endtask

    // Behavioural model state
    logic [31:0] m_pc, m_bpc [8], m_btgt [8];
    logic        m_v, m_f, m_m, m_bv [8];

    function automatic logic [31:0] resolve();
        case (ex_op)
            NPC_PC4: return ex_pc + 32'd4;
            NPC_B:   return ex_taken ? ex_pc + ex_offset : ex_pc + 32'd4;
            NPC_JAL: return ex_pc + ex_offset;
            default: return {ex_jalr_tgt[31:1], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] m_pred(input logic [31:0] p);
`ifdef NPC_BTB_EN
        int i = int'((p >> 2) % 8);
        return (m_bv[i] && m_bpc[i][31:2] == p[31:2]) ? m_btgt[i] : p + 32'd4;
`else
        return p + 32'd4;
`endif
    endfunction

    task automatic model_edge();
        logic [31:0] a, np;
        logic        mis, mp;
        int          i;
        if (rst) begin
            m_pc = 32'h0; m_v = 1'b0; m_f = 1'b0; m_m = 1'b0;
            foreach (m_bv[k]) m_bv[k] = 1'b0;
        end else begin
            a   = resolve();
            mis = ex_valid && a[1];
            mp  = ex_valid && a != ex_pred_npc;
            np  = mis ? 32'h100 : mp ? a : (m_v && if_ready && !stall) ? m_pred(m_pc) : m_pc;
            i   = int'((ex_pc >> 2) % 8);
            if (ex_valid && !mis) begin
                if (ex_op == NPC_JAL || ex_op == NPC_JALR || (ex_op == NPC_B && ex_taken)) begin
                    m_bv[i] = 1'b1; m_bpc[i] = ex_pc; m_btgt[i] = a;
                end else if (ex_op == NPC_B && m_bv[i] && m_bpc[i][31:2] == ex_pc[31:2])
                    m_bv[i] = 1'b0;
            end
            m_pc = np; m_v = 1'b1; m_f = mis || mp; m_m = mis;
        end
    endtask

    typedef struct {
        logic r, rdy, st, ev; logic [1:0] op; logic tk;
        logic [31:0] epc, off, jt, pr, xpc; logic xv, xf, xm;
    } vec_t;
    vec_t tbl [23];

    function automatic vec_t v(input logic r, input logic rdy, input logic st, input logic ev,
                               input logic [1:0] op, input logic tk, input logic [31:0] epc,
                               input logic [31:0] off, input logic [31:0] jt, input logic [31:0] pr,
                               input logic [31:0] xpc, input logic xv, input logic xf, input logic xm);
        vec_t t;
        t.r = r; t.rdy = rdy; t.st = st; t.ev = ev; t.op = op; t.tk = tk; t.epc = epc;
        t.off = off; t.jt = jt; t.pr = pr; t.xpc = xpc; t.xv = xv; t.xf = xf; t.xm = xm;
        return t;
    endfunction

    initial begin
        tbl[0]  = v(1,0,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h0,  0,0,0);
        tbl[1]  = v(1,0,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h0,  0,0,0);
        tbl[2]  = v(0,1,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h0,  1,0,0);
        tbl[3]  = v(0,1,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h4,  1,0,0);
        tbl[4]  = v(0,1,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h8,  1,0,0);
        tbl[5]  = v(0,1,1,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h8,  1,0,0);
        tbl[6]  = v(0,1,1,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h8,  1,0,0);
        tbl[7]  = v(0,1,1,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h8,  1,0,0);
        tbl[8]  = v(0,1,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'hC,  1,0,0);
        tbl[9]  = v(0,1,0,1,NPC_B,   1,32'h10,      32'hFFFFFFF8,32'h0,  32'h14,  32'h8,  1,1,0);
        tbl[10] = v(0,1,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'hC,  1,0,0);
        tbl[11] = v(0,1,0,1,NPC_B,   1,32'h10,      32'hFFFFFFF8,32'h0,  32'h8,   32'h10, 1,0,0);
        tbl[12] = v(0,1,0,1,NPC_JALR,0,32'h40,      32'h0,       32'h201,32'h0,   32'h200,1,1,0);
        tbl[13] = v(0,1,0,1,NPC_JALR,0,32'h40,      32'h0,       32'h206,32'h206, 32'h100,1,1,1);
        tbl[14] = v(0,1,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h104,1,0,0);
        tbl[15] = v(0,1,1,1,NPC_JAL, 0,32'h30,      32'h50,      32'h0,  32'h0,   32'h80, 1,1,0);
        tbl[16] = v(0,1,1,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h80, 1,0,0);
        tbl[17] = v(1,1,0,1,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h44,  32'h0,  0,0,0);
        tbl[18] = v(0,1,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h0,  1,0,0);
        tbl[19] = v(0,0,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h0,  1,0,0);
        tbl[20] = v(0,1,0,0,NPC_PC4, 0,32'h0,       32'h0,       32'h0,  32'h0,   32'h4,  1,0,0);
        tbl[21] = v(0,1,0,1,NPC_PC4, 0,32'hFFFFFFFC,32'h0,       32'h0,  32'h0,   32'h8,  1,0,0);
        tbl[22] = v(0,1,0,1,NPC_PC4, 0,32'hFFFFFFFC,32'h0,       32'h0,  32'h4,   32'h0,  1,1,0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].rdy, tbl[i].st, tbl[i].ev, tbl[i].op, tbl[i].tk,
                  tbl[i].epc, tbl[i].off, tbl[i].jt, tbl[i].pr);
            model_edge();
            tick();
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].xpc);
            chk($sformatf("vec%0d_valid", i), 32'(pc_valid), 32'(tbl[i].xv));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].xf));
            chk($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(tbl[i].xm));
            chk($sformatf("vec%0d_pc4", i), pc4, tbl[i].xpc + 32'd4);
        end

        for (int n = 0; n < 400; n++) begin
            rst         = $urandom_range(0, 39) == 0;
            if_ready    = $urandom_range(0, 3) != 0;
            stall       = $urandom_range(0, 4) == 0;
            ex_valid    = (m_v || rst) && $urandom_range(0, 1) == 1;
            ex_op       = 2'($urandom_range(0, 3));
            ex_taken    = $urandom_range(0, 1) == 1;
            ex_pc       = 32'($urandom_range(0, 63)) << 2;
            ex_offset   = (32'($urandom_range(0, 63)) << 1) - 32'd64;
            ex_jalr_tgt = 32'($urandom_range(0, 511));
            ex_pred_npc = $urandom_range(0, 1) == 1 ? resolve() : 32'($urandom_range(0, 63)) << 2;
            model_edge();
            tick();
            chk("rnd_pc", pc, m_pc);
            chk("rnd_valid", 32'(pc_valid), 32'(m_v));
            chk("rnd_flush", 32'(flush), 32'(m_f));
            chk("rnd_misalign", 32'(misalign), 32'(m_m));
            chk("rnd_pred_npc", pred_npc, m_pred(m_pc));
        end

`ifdef NPC_BTB_EN
        drive(1,1,0,0,NPC_PC4,0,0,0,0,0); tick();
        drive(0,1,0,0,NPC_PC4,0,0,0,0,0); tick();
        drive(0,1,0,1,NPC_JAL,0,32'h20,32'h60,0,32'h24); tick();
        chk("btb_first_flush", 32'(flush), 32'd1);
        chk("btb_first_pc", pc, 32'h80);
        drive(0,1,0,1,NPC_PC4,0,32'h1C,0,0,32'h0); tick();
        chk("btb_refetch_pc", pc, 32'h20);
        chk("btb_hit_pred", pred_npc, 32'h80);
        drive(0,1,0,1,NPC_JAL,0,32'h20,32'h60,0,32'h80); tick();
        chk("btb_reuse_flush", 32'(flush), 32'd0);
        chk("btb_reuse_pc", pc, 32'h80);
        drive(0,1,0,1,NPC_B,0,32'h20,32'h60,0,32'h24); tick();
        chk("btb_nt_flush", 32'(flush), 32'd0);
        drive(0,1,0,1,NPC_PC4,0,32'h1C,0,0,32'h0); tick();
        chk("btb_inv_pc", pc, 32'h20);
        chk("btb_inv_pred", pred_npc, 32'h24);
        drive(0,1,0,0,NPC_PC4,0,0,0,0,0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
